// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, mode-register layout, error codes and init states.
package sdram_pkg;

    // {nRAS, nCAS, nWE}
    localparam logic [2:0] CMD_NOP   = 3'b111;
    localparam logic [2:0] CMD_ACT   = 3'b011;
    localparam logic [2:0] CMD_READ  = 3'b101;
    localparam logic [2:0] CMD_WRITE = 3'b100;
    localparam logic [2:0] CMD_PRE   = 3'b010;
    localparam logic [2:0] CMD_REF   = 3'b001;
    localparam logic [2:0] CMD_LMR   = 3'b000;

    localparam int MR_BL_LSB = 0;
    localparam int MR_CL_LSB = 4;
    localparam int A_AP_BIT  = 10;

    localparam logic [2:0] ERR_NONE        = 3'd0;
    localparam logic [2:0] ERR_INIT        = 3'd1;
    localparam logic [2:0] ERR_ACT_OPEN    = 3'd2;
    localparam logic [2:0] ERR_BANK_CLOSED = 3'd3;
    localparam logic [2:0] ERR_TRCD        = 3'd4;
    localparam logic [2:0] ERR_REF_OPEN    = 3'd5;
    localparam logic [2:0] ERR_MODE        = 3'd6;
    localparam logic [2:0] ERR_REF_LATE    = 3'd7;

    typedef enum logic [2:0] {
        W_PRE  = 3'd0,
        W_REF1 = 3'd1,
        W_REF2 = 3'd2,
        W_MODE = 3'd3,
        RUN    = 3'd4
    } init_state_e;

endpackage

// File: rtl/sdram_resp_bank.sv
// Per-bank state: open flag, open row and tRCD down-counter.
module sdram_resp_bank #(
    parameter int TRCD = 2
) (
    input  logic        clk,
    input  logic        init,
    input  logic        act_i,
    input  logic        pre_i,
    input  logic        rw_i,
    input  logic        ap_i,
    input  logic [12:0] row_i,
    output logic        open_o,
    output logic [12:0] row_o,
    output logic        trcd_ok_o
);
    localparam int CW = (TRCD > 1) ? $clog2(TRCD) : 1;
    localparam logic [CW-1:0] TRCD_LOAD = CW'(TRCD - 1);

    logic          open_q, open_d;
    logic [12:0]   row_q, row_d;
    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        open_d = open_q;
        row_d  = row_q;
        cnt_d  = (cnt_q != '0) ? cnt_q - 1'b1 : cnt_q;
        if (act_i) begin
            open_d = 1'b1;
            row_d  = row_i;
            cnt_d  = TRCD_LOAD;
        end else if (pre_i || (rw_i && ap_i)) begin
            open_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (init) begin
            open_q <= 1'b0;
            row_q  <= '0;
            cnt_q  <= '0;
        end else begin
            open_q <= open_d;
            row_q  <= row_d;
            cnt_q  <= cnt_d;
        end
    end

    assign open_o    = open_q;
    assign row_o     = row_q;
    assign trcd_ok_o = (cnt_q == '0);

endmodule

// File: rtl/sdram_responder.sv
// SDR SDRAM device-side responder with init/legality checking.
// Optional refresh-interval check enabled by defining SDRAM_RESP_REFCHK_EN.
module sdram_responder
    import sdram_pkg::*;
#(
    parameter int MEM_AW    = 16,
    parameter int TRCD      = 2,
    parameter int REF_LIMIT = 1600
) (
    input  logic        clk,
    input  logic        init,
    input  logic        SDRAM_nCS,
    input  logic        SDRAM_nRAS,
    input  logic        SDRAM_nCAS,
    input  logic        SDRAM_nWE,
    input  logic [1:0]  SDRAM_BA,
    input  logic [12:0] SDRAM_A,
    input  logic        SDRAM_DQML,
    input  logic        SDRAM_DQMH,
    input  logic [15:0] dq_in,
    output logic [15:0] dq_out,
    output logic        dq_oe,
    output logic        dev_ready,
    output logic        err,
    output logic [2:0]  err_code,
    output logic [15:0] ref_cnt
);
    init_state_e state_q, state_d;
    logic [2:0]  cl_q, cl_d;
    logic        err_q;
    logic [2:0]  code_q;
    logic [15:0] ref_q;
    logic [2:0]        vld_q, vld_d;
    logic [2:0][15:0]  dat_q, dat_d;

    logic [2:0] cmd;
    logic       run, a10, is_act, is_pre, is_rd, is_wr;
    logic       sel_open, sel_ok, rd_hit, wr_hit;
    logic [3:0]        bank_open, bank_ok;
    logic [3:0][12:0]  bank_row;
    logic [MEM_AW-1:0] mem_addr;
    logic [15:0]       rd_word;
    logic              e_vld, ref_late;
    logic [2:0]        e_code;
    logic [2:0]        mr_cl, mr_bl;

    logic [15:0] mem [0:(1<<MEM_AW)-1];

    assign cmd      = SDRAM_nCS ? CMD_NOP : {SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE};
    assign run      = (state_q == RUN);
    assign a10      = SDRAM_A[A_AP_BIT];
    assign is_act   = run && (cmd == CMD_ACT);
    assign is_pre   = run && (cmd == CMD_PRE);
    assign is_rd    = run && (cmd == CMD_READ);
    assign is_wr    = run && (cmd == CMD_WRITE);
    assign sel_open = bank_open[SDRAM_BA];
    assign sel_ok   = bank_ok[SDRAM_BA];
    assign rd_hit   = is_rd && sel_open;
    assign wr_hit   = is_wr && sel_open;
    assign mem_addr = MEM_AW'({SDRAM_BA, bank_row[SDRAM_BA], SDRAM_A[8:0]});
    assign rd_word  = mem[mem_addr];
    assign mr_cl    = SDRAM_A[MR_CL_LSB +: 3];
    assign mr_bl    = SDRAM_A[MR_BL_LSB +: 3];

    for (genvar b = 0; b < 4; b++) begin : g_bank
        sdram_resp_bank #(.TRCD(TRCD)) u_bank (
            .clk       (clk),
            .init      (init),
            .act_i     (is_act && (SDRAM_BA == 2'(b))),
            .pre_i     (is_pre && (a10 || (SDRAM_BA == 2'(b)))),
            .rw_i      ((rd_hit || wr_hit) && (SDRAM_BA == 2'(b))),
            .ap_i      (a10),
            .row_i     (SDRAM_A),
            .open_o    (bank_open[b]),
            .row_o     (bank_row[b]),
            .trcd_ok_o (bank_ok[b])
        );
    end

`ifdef SDRAM_RESP_REFCHK_EN
    logic [15:0] age_q, age_d;
    always_comb begin
        if (!run || cmd == CMD_REF) age_d = '0;
        else                        age_d = (age_q == 16'hFFFF) ? age_q : age_q + 16'd1;
    end
    assign ref_late = run && (cmd != CMD_REF) && ({16'd0, age_d} > 32'(REF_LIMIT));
    always_ff @(posedge clk) begin
        if (init) age_q <= '0;
        else      age_q <= age_d;
    end
`else
    assign ref_late = (REF_LIMIT < 0);
`endif

    always_comb begin
        state_d = state_q;
        cl_d    = cl_q;
        e_vld   = 1'b0;
        e_code  = ERR_NONE;
        if (cmd != CMD_NOP) begin
            if (!run) begin
                if      (state_q == W_PRE  && cmd == CMD_PRE && a10) state_d = W_REF1;
                else if (state_q == W_REF1 && cmd == CMD_REF)        state_d = W_REF2;
                else if (state_q == W_REF2 && cmd == CMD_REF)        state_d = W_MODE;
                else if (state_q == W_MODE && cmd == CMD_LMR)        state_d = RUN;
                else begin
                    e_vld  = 1'b1;
                    e_code = ERR_INIT;
                end
            end else begin
                case (cmd)
                    CMD_ACT: if (sel_open) begin e_vld = 1'b1; e_code = ERR_ACT_OPEN; end
                    CMD_READ, CMD_WRITE: begin
                        if (!sel_open)   begin e_vld = 1'b1; e_code = ERR_BANK_CLOSED; end
                        else if (!sel_ok) begin e_vld = 1'b1; e_code = ERR_TRCD; end
                    end
                    CMD_REF: if (|bank_open) begin e_vld = 1'b1; e_code = ERR_REF_OPEN; end
                    default: ;
                endcase
            end
            if (cmd == CMD_LMR && (run || state_q == W_MODE)) begin
                cl_d = mr_cl;
                if (mr_bl != 3'd0 || (mr_cl != 3'd2 && mr_cl != 3'd3)) begin
                    e_vld  = 1'b1;
                    e_code = ERR_MODE;
                end
            end
        end
        if (!e_vld && ref_late) begin
            e_vld  = 1'b1;
            e_code = ERR_REF_LATE;
        end
    end

    // Read data enters the shift register CL-1 stages from the output, so it
    // surfaces CL-1 edges after the READ edge; invalid CL fields act as CL=2.
    always_comb begin
        vld_d    = {1'b0, vld_q[2:1]};
        dat_d[0] = dat_q[1];
        dat_d[1] = dat_q[2];
        dat_d[2] = dat_q[2];
        if (rd_hit) begin
            if (cl_q == 3'd3) begin
                vld_d[2] = 1'b1;
                dat_d[2] = rd_word;
            end else begin
                vld_d[1] = 1'b1;
                dat_d[1] = rd_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (init) begin
            state_q <= W_PRE;
            cl_q    <= 3'd2;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
            ref_q   <= '0;
            vld_q   <= '0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cl_q    <= cl_d;
            vld_q   <= vld_d;
            dat_q   <= dat_d;
            if (cmd == CMD_REF) ref_q <= ref_q + 16'd1;
            if (e_vld && !err_q) begin
                err_q  <= 1'b1;
                code_q <= e_code;
            end
        end
    end

    // Array is deliberately not reset so contents survive init.
    always_ff @(posedge clk) begin
        if (!init && wr_hit) begin
            if (!SDRAM_DQML) mem[mem_addr][7:0]  <= dq_in[7:0];
            if (!SDRAM_DQMH) mem[mem_addr][15:8] <= dq_in[15:8];
        end
    end

    assign dq_oe     = vld_q[0];
    assign dq_out    = vld_q[0] ? dat_q[0] : 16'd0;
    assign dev_ready = run;
    assign err       = err_q;
    assign err_code  = code_q;
    assign ref_cnt   = ref_q;

endmodule

// File: tb/tb_sdram_responder.sv
// Directed + randomized bench for sdram_responder against a command-level model.
module tb_sdram_responder;
    localparam int MEM_AW    = 16;
    localparam int TRCD      = 2;
    localparam int REF_LIMIT = 100;

    localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_RD = 3'b101, C_WR = 3'b100,
                           C_PRE = 3'b010, C_REF = 3'b001, C_LMR = 3'b000;

    logic        clk = 1'b0;
    logic        init = 1'b1;
    logic        nCS = 1'b1, nRAS = 1'b1, nCAS = 1'b1, nWE = 1'b1;
    logic [1:0]  BA = '0;
    logic [12:0] A = '0;
    logic        DQML = 1'b0, DQMH = 1'b0;
    logic [15:0] dq_in = '0;
    logic [15:0] dq_out;
    logic        dq_oe, dev_ready, err;
    logic [2:0]  err_code;
    logic [15:0] ref_cnt;

    always #5 clk = ~clk;

    sdram_responder #(.MEM_AW(MEM_AW), .TRCD(TRCD), .REF_LIMIT(REF_LIMIT)) dut (
        .clk(clk), .init(init), .SDRAM_nCS(nCS), .SDRAM_nRAS(nRAS), .SDRAM_nCAS(nCAS),
        .SDRAM_nWE(nWE), .SDRAM_BA(BA), .SDRAM_A(A), .SDRAM_DQML(DQML), .SDRAM_DQMH(DQMH),
        .dq_in(dq_in), .dq_out(dq_out), .dq_oe(dq_oe), .dev_ready(dev_ready),
        .err(err), .err_code(err_code), .ref_cnt(ref_cnt)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // model state: init progress 0..3, 4 = running
    int          m_state;
    bit          m_open [4];
    int          m_row [4];
    int          m_act_t [4];
    int          m_cl;
    bit          m_err;
    int          m_code;
    int          m_ref;
    int          m_last_ref;
    logic [15:0] m_mem [int];
    typedef struct { int due; logic [15:0] d; } rd_t;
    rd_t rq [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int maddr(input int b, input int row, input int col);
        return (b * (1 << 22) + row * 512 + col) % (1 << MEM_AW);
    endfunction

    task automatic mode_set(input int a, inout int code);
        m_cl = (a >> 4) & 7;
        if ((a & 7) != 0 || (m_cl != 2 && m_cl != 3)) code = 6;
    endtask

    task automatic step(input bit rst, input logic [2:0] c, input int ba, input int a,
                        input bit mh, input bit ml, input logic [15:0] d);
        int   code;
        bit   running;
        int   addr;
        rd_t  e;
        logic [15:0] w;
        init = rst; nCS = 1'b0; {nRAS, nCAS, nWE} = c;
        BA = 2'(ba); A = 13'(a); DQMH = mh; DQML = ml; dq_in = d;
        @(posedge clk);
        cyc++;
        if (rst) begin
            m_state = 0; m_err = 0; m_code = 0; m_ref = 0; rq.delete();
            for (int i = 0; i < 4; i++) m_open[i] = 0;
        end else begin
            code = 0;
            running = (m_state == 4);
            if (c == C_REF) m_ref = (m_ref + 1) % 65536;
            if (c != C_NOP) begin
                if (!running) begin
                    if (m_state == 0 && c == C_PRE && a[10]) m_state = 1;
                    else if (m_state == 1 && c == C_REF) m_state = 2;
                    else if (m_state == 2 && c == C_REF) m_state = 3;
                    else if (m_state == 3 && c == C_LMR) begin
                        m_state = 4; m_last_ref = cyc; mode_set(a, code);
                    end else code = 1;
                end else begin
                    case (c)
                        C_ACT: begin
                            if (m_open[ba]) code = 2;
                            m_open[ba] = 1; m_row[ba] = a; m_act_t[ba] = cyc;
                        end
                        C_RD, C_WR: begin
                            if (!m_open[ba]) code = 3;
                            else begin
                                if (cyc - m_act_t[ba] < TRCD) code = 4;
                                addr = maddr(ba, m_row[ba], a % 512);
                                if (c == C_RD) begin
                                    e.due = cyc + ((m_cl == 3) ? 3 : 2) - 1;
                                    e.d   = m_mem[addr];
                                    rq.push_back(e);
                                end else begin
                                    w = m_mem.exists(addr) ? m_mem[addr] : 16'hxxxx;
                                    if (!ml) w[7:0]  = d[7:0];
                                    if (!mh) w[15:8] = d[15:8];
                                    m_mem[addr] = w;
                                end
                                if (a[10]) m_open[ba] = 0;
                            end
                        end
                        C_PRE: begin
                            if (a[10]) for (int i = 0; i < 4; i++) m_open[i] = 0;
                            else m_open[ba] = 0;
                        end
                        C_REF: begin
                            if (m_open[0] || m_open[1] || m_open[2] || m_open[3]) code = 5;
                            m_last_ref = cyc;
                        end
                        C_LMR: mode_set(a, code);
                        default: ;
                    endcase
                end
            end
`ifdef SDRAM_RESP_REFCHK_EN
            if (running && c != C_REF && code == 0 && cyc - m_last_ref > REF_LIMIT) code = 7;
`endif
            if (code != 0 && !m_err) begin m_err = 1; m_code = code; end
        end
        #1;
        if (rq.size() > 0 && rq[0].due == cyc) begin
            chk("m_oe", dq_oe, 1);
            chk("m_dout", dq_out, rq[0].d);
            void'(rq.pop_front());
        end else chk("m_oe_idle", dq_oe, 0);
        chk("m_err", err, m_err);
        chk("m_code", err_code, m_code);
        chk("m_ready", dev_ready, m_state == 4);
        chk("m_refcnt", ref_cnt, m_ref);
    endtask

    task automatic nop();                          step(0, C_NOP, 0, 0, 0, 0, 0); endtask
    task automatic cmd(input logic [2:0] c, input int ba, input int a); step(0, c, ba, a, 0, 0, 0); endtask
    task automatic wr(input int ba, input int a, input logic [15:0] d, input bit mh, input bit ml);
        step(0, C_WR, ba, a, mh, ml, d);
    endtask
    task automatic rst();        step(1, C_NOP, 0, 0, 0, 0, 0); step(1, C_NOP, 0, 0, 0, 0, 0); endtask
    task automatic init_seq(input int mode);
        cmd(C_PRE, 0, 'h400); cmd(C_REF, 0, 0); cmd(C_REF, 0, 0); cmd(C_LMR, 0, mode);
    endtask

    initial begin
        int b, col, r, addr, ap;
        // reset state
        rst();
        chk("rst_oe", dq_oe, 0); chk("rst_dout", dq_out, 0); chk("rst_ready", dev_ready, 0);
        chk("rst_err", err, 0); chk("rst_refcnt", ref_cnt, 0);

        // init sequence, CL=2
        init_seq('h220);
        chk("init_ready", dev_ready, 1); chk("init_err", err, 0); chk("init_refcnt", ref_cnt, 2);

        // write with auto-precharge, reopen, read back
        cmd(C_ACT, 1, 5); nop();
        wr(1, 'h412, 16'hBEEF, 0, 0);
        cmd(C_ACT, 1, 5); nop();
        cmd(C_RD, 1, 'h012);  chk("rd_lat_n", dq_oe, 0);
        nop();                chk("rd_oe", dq_oe, 1); chk("rd_data", dq_out, 16'hBEEF);
        nop();                chk("rd_oe_once", dq_oe, 0);

        // high byte masked
        wr(1, 'h012, 16'h1234, 1, 0);
        cmd(C_RD, 1, 'h012); nop(); chk("mask_data", dq_out, 16'hBE34);

        // back-to-back reads, then a write to the just-read word
        wr(1, 'h013, 16'hA5A5, 0, 0);
        cmd(C_RD, 1, 'h013);
        cmd(C_RD, 1, 'h012); chk("b2b_first", dq_out, 16'hA5A5);
        wr(1, 'h012, 16'h0000, 0, 0); chk("b2b_second", dq_out, 16'hBE34);

        // CL=3
        cmd(C_LMR, 0, 'h230);
        cmd(C_RD, 1, 'h013); nop(); chk("cl3_early", dq_oe, 0);
        nop();               chk("cl3_oe", dq_oe, 1); chk("cl3_data", dq_out, 16'hA5A5);
        cmd(C_LMR, 0, 'h220);

        // closed-bank read, later errors ignored, init clears
        cmd(C_PRE, 0, 'h400);
        cmd(C_RD, 2, 0);     chk("closed_err", err, 1); chk("closed_code", err_code, 3);
        cmd(C_ACT, 0, 1); cmd(C_ACT, 0, 1); chk("sticky_code", err_code, 3);
        rst();               chk("clr_err", err, 0);

        // tRCD violation still returns data
        init_seq('h220);
        cmd(C_ACT, 1, 5); cmd(C_RD, 1, 'h012); chk("trcd_code", err_code, 4);
        nop();               chk("trcd_oe", dq_oe, 1); chk("trcd_data", dq_out, 16'h0000);

        // command before init completes
        rst(); cmd(C_RD, 1, 'h012); chk("preinit_code", err_code, 1); nop(); chk("preinit_nord", dq_oe, 0);

        // bad mode, open-bank ACT, refresh with open bank
        rst(); init_seq('h221); chk("mode_code", err_code, 6); chk("mode_ready", dev_ready, 1);
        rst(); init_seq('h220); cmd(C_ACT, 0, 3); cmd(C_ACT, 0, 3); chk("act_code", err_code, 2);
        rst(); init_seq('h220); cmd(C_ACT, 2, 3); cmd(C_REF, 0, 0); chk("ref_code", err_code, 5);
        chk("ref_cnt_inc", ref_cnt, 3);

        // refresh interval
        rst(); init_seq('h220);
        repeat (REF_LIMIT + 5) nop();
`ifdef SDRAM_RESP_REFCHK_EN
        chk("late_err", err, 1); chk("late_code", err_code, 7);
`else
        chk("late_none", err, 0);
`endif

        // randomized legal traffic
        rst(); init_seq(($urandom_range(0, 1) == 1) ? 'h230 : 'h220);
        for (int i = 0; i < 600; i++) begin
            b   = $urandom_range(0, 3);
            col = $urandom_range(0, 7);
            ap  = ($urandom_range(0, 3) == 0) ? 'h400 : 0;
            if (i % 50 == 0) begin
                cmd(C_PRE, 0, 'h400); cmd(C_REF, 0, 0);
            end else if (!m_open[b]) cmd(C_ACT, b, $urandom_range(0, 3));
            else if (cyc - m_act_t[b] < TRCD) nop();
            else begin
                addr = maddr(b, m_row[b], col);
                r = $urandom_range(0, 99);
                if (r < 45 && m_mem.exists(addr)) cmd(C_RD, b, ap + col);
                else if (r < 90 || !m_mem.exists(addr)) begin
                    if (m_mem.exists(addr))
                        wr(b, ap + col, 16'($urandom), bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
                    else
                        wr(b, ap + col, 16'($urandom), 0, 0);
                end else cmd(C_PRE, b, 0);
            end
        end
        repeat (4) nop();
        chk("rand_err", err, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sdram_responder.md
Name: sdram_responder

Overview:
- Synthesizable responder for the SDR SDRAM command interface (MT48LC16M16A2 subset); the device end of our SDRAM controller's pin interface.
- Decodes nRAS/nCAS/nWE/BA/A/DQM, tracks per-bank open rows, and serves reads/writes from an internal word array.
- Checks init sequence and command legality, reporting the first violation.
- Used in benches and in loopback builds in place of the physical chip.

Parameters:
- MEM_AW, 16, word-address bits of the backing array (2^MEM_AW x 16); the {bank,row,col} word address is truncated to its low MEM_AW bits.
- TRCD, 2, minimum cycles from ACTIVE to READ/WRITE on the same bank.
- REF_LIMIT, 1600, maximum cycles between AUTO_REFRESH commands (used only with the optional feature).

Ports:
- clk  in  1  clock; all commands are sampled on the rising edge.
- init  in  1  synchronous active-high reset.
- SDRAM_nCS  in  1  chip select; command ignored (NOP) when high.
- SDRAM_nRAS  in  1  row address select.
- SDRAM_nCAS  in  1  column address select.
- SDRAM_nWE  in  1  write enable.
- SDRAM_BA  in  2  bank.
- SDRAM_A  in  13  row address, column A[8:0], A10 = auto-precharge/all-banks.
- SDRAM_DQML  in  1  low-byte write mask.
- SDRAM_DQMH  in  1  high-byte write mask.
- dq_in  in  16  write data, sampled together with WRITE.
- dq_out  out  16  read data.
- dq_oe  out  1  read data drive enable.
- dev_ready  out  1  init sequence complete.
- err  out  1  sticky violation flag.
- err_code  out  3  code of the first violation.
- ref_cnt  out  16  AUTO_REFRESH count, wraps at 2^16.

Behaviour:
- Reset: while init is asserted, every output is 0, all banks are closed, the read pipeline is flushed, and the init FSM returns to W_PRE. Array contents are preserved.
- Command encoding {nRAS,nCAS,nWE}: 111 NOP, 011 ACTIVE, 101 READ, 100 WRITE, 010 PRECHARGE, 001 AUTO_REFRESH, 000 LOAD_MODE.
- Init FSM transitions:
  - W_PRE -> W_REF1 on PRECHARGE with A10=1.
  - W_REF1 -> W_REF2 on AUTO_REFRESH.
  - W_REF2 -> W_MODE on AUTO_REFRESH.
  - W_MODE -> RUN on LOAD_MODE; latch CL=A[6:4] and BL=A[2:0]; dev_ready=1 from the next cycle.
  - Any other non-NOP command before RUN raises err code 1 and leaves the state unchanged.
- LOAD_MODE with BL!=000, or CL not 2 or 3, raises code 6. The mode is latched regardless; a READ then uses CL=2 if the CL field is invalid.
- ACTIVE: opens row A on bank BA and loads the bank's tRCD counter with TRCD-1. Raises code 2 if the bank is already open.
- READ/WRITE:
  - Bank must be open, otherwise code 3 and no access.
  - tRCD counter must be 0, otherwise code 4; the access still executes.
  - Word address = {BA, open row, A[8:0]} truncated to MEM_AW bits.
  - A10=1 closes the bank after the access.
- WRITE: byte-enables are ~DQMH/~DQML; a fully masked write leaves memory unchanged.
- READ: DQM is ignored. Sampled at edge N, dq_out/dq_oe are registered at edge N+CL-1 and held for exactly one cycle (BL=1).
  - Back-to-back READs give consecutive data cycles.
  - A WRITE to the same address in the cycle after a READ does not alter that READ's data, because the word is captured at the READ edge.
- PRECHARGE: A10=1 closes all banks; otherwise closes bank BA. Precharging a closed bank is legal.
- AUTO_REFRESH: raises code 5 if any bank is open; ref_cnt increments in every case.
- Error reporting: err/err_code latch the first error only. A later error in the same or subsequent cycles is ignored until init.
- Read pipeline is a shift register of depth 3. Data already in flight completes even if a PRECHARGE or ACTIVE follows.

Optional Feature:
- Macro SDRAM_RESP_REFCHK_EN.
- Defined: in RUN, a counter clears on AUTO_REFRESH and raises code 7 when it exceeds REF_LIMIT.
- Not defined: no counter exists, code 7 is never produced, and REF_LIMIT is unused.

Decomposition:
- Package sdram_pkg holds:
  - command localparams (shared with the controller);
  - mode-register field offsets;
  - error-code localparams 1..7;
  - init FSM state enum.
- Sub-module sdram_resp_bank: one per bank (x4). Holds the open flag, row register and tRCD down-counter. Inputs: act/pre/rw strobes; outputs: open, row, trcd_ok.

Test Plan:
- Init: PRE-all, REF, REF, LOAD_MODE 0x220 -> dev_ready=1 the next cycle, err=0, ref_cnt=2.
- Write/read: ACT bank1 row 0x0005; WRITE col 0x012 with data 0xBEEF, DQM=00; ACT again; READ at edge N -> dq_oe=1 and dq_out=0xBEEF at edge N+1 only.
- Byte mask: preload 0xBEEF, WRITE 0x1234 with DQMH=1, DQML=0 -> readback 0xBE34. Then CL=3 mode -> data appears at N+2.
- Violations: READ on a closed bank -> err=1, code 3. A following ACT on an open bank keeps code 3. init clears err.
- Timing: ACT at edge 10, READ at edge 11 with TRCD=2 -> code 4, data is still returned. A READ before init -> code 1.
- Refresh: with SDRAM_RESP_REFCHK_EN, REF_LIMIT=100 and no refresh for 101 cycles -> code 7. Without the macro -> err stays 0.
